// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined float multiplier, round-to-nearest-even, flush-to-zero
// Ports: clock/reset (sync, active-high); in_valid/in_ready + a/b operand handshake;
//        out_valid/out_ready + result product handshake; flags {invalid, overflow,
//        underflow, inexact} present only when FP_MULT_FLAGS_EN is defined.
module fp_mult_pipe #(
    parameter int EXP_BITS = 8,
    parameter int FRAC_BITS = 23,
    localparam int W = 1 + EXP_BITS + FRAC_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
`ifdef FP_MULT_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);
    localparam int E = EXP_BITS;
    localparam int F = FRAC_BITS;
    localparam int P = 2 * F + 2;
    localparam int X = E + 2;
    localparam int BIAS = 2 ** (E - 1) - 1;
    localparam int EMAX = 2 ** E - 1;

    typedef enum logic [1:0] {T_NUM, T_NAN, T_INF, T_ZERO} tag_t;

    logic en;
    logic [E-1:0] ea, eb;
    logic [F-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    tag_t tag;
    logic signed [X-1:0] esum;
    logic v1, v2;
    logic s1_sign, s2_sign;
    tag_t s1_tag, s2_tag;
    logic signed [X-1:0] s1_exp, s2_exp;
    logic [F:0] s1_ma, s1_mb;
    logic [P-1:0] s2_p;
    logic hi, g, st, rnd, ovf, unf;
    logic [F-1:0] frac;
    logic [F:0] frac_r;
    logic signed [X-1:0] inc, e_fin;
    logic [W-1:0] res;

    assign en = !out_valid || out_ready;
    assign in_ready = en;

    // Exponent zero covers both true zero and denormals, which are flushed.
    always_comb begin
        ea = a[W-2:F];
        eb = b[W-2:F];
        fa = a[F-1:0];
        fb = b[F-1:0];
        a_zero = ~|ea;
        b_zero = ~|eb;
        a_nan = &ea && |fa;
        b_nan = &eb && |fb;
        a_inf = &ea && ~|fa;
        b_inf = &eb && ~|fb;
        tag = (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf)) ? T_NAN :
              (a_inf || b_inf) ? T_INF :
              (a_zero || b_zero) ? T_ZERO : T_NUM;
        esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(X'(BIAS));
    end

    // Product is 1x.xxx or 01.xxx; pick the fraction window, guard and sticky accordingly.
    always_comb begin
        hi = s2_p[P-1];
        frac = hi ? s2_p[P-2:F+1] : s2_p[P-3:F];
        g = hi ? s2_p[F] : s2_p[F-1];
        st = hi ? |s2_p[F-1:0] : |s2_p[F-2:0];
        rnd = g && (st || frac[0]);
        frac_r = {1'b0, frac} + (F + 1)'(rnd);
        inc = X'(hi) + X'(frac_r[F]);
        e_fin = s2_exp + inc;
        ovf = !e_fin[X-1] && (e_fin[X-2:0] >= (X - 1)'(EMAX));
        unf = e_fin[X-1] || ~|e_fin;
        res = (s2_tag == T_NAN) ? {1'b0, {E{1'b1}}, 1'b1, {(F - 1){1'b0}}} :
              (s2_tag == T_INF || (s2_tag == T_NUM && ovf)) ? {s2_sign, {E{1'b1}}, {F{1'b0}}} :
              (s2_tag == T_ZERO || (s2_tag == T_NUM && unf)) ? {s2_sign, {(W - 1){1'b0}}} :
              {s2_sign, e_fin[E-1:0], frac_r[F-1:0]};
    end

`ifdef FP_MULT_FLAGS_EN
    logic [3:0] flg;
    always_comb begin
        flg = {s2_tag == T_NAN,
               s2_tag == T_NUM && ovf,
               s2_tag == T_NUM && unf,
               s2_tag == T_NUM && (g || st || ovf || unf)};
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            result <= '0;
`ifdef FP_MULT_FLAGS_EN
            flags <= '0;
`endif
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            out_valid <= v2;
            s1_sign <= a[W-1] ^ b[W-1];
            s1_tag <= tag;
            s1_exp <= esum;
            s1_ma <= {1'b1, fa};
            s1_mb <= {1'b1, fb};
            s2_sign <= s1_sign;
            s2_tag <= s1_tag;
            s2_exp <= s1_exp;
            s2_p <= P'(s1_ma) * P'(s1_mb);
            if (v2) begin
                result <= res;
`ifdef FP_MULT_FLAGS_EN
                flags <= flg;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed scoreboard bench for fp_mult_pipe (single precision)
module tb_fp_mult_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic in_ready, out_valid;
    logic [31:0] result;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0] flags;
`endif
    int checks = 0;
    int errors = 0;
    logic [35:0] q[$];

    fp_mult_pipe dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
`ifdef FP_MULT_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r, input logic [3:0] f);
        int n = 0;
        @(negedge clock);
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        assert (in_ready) else begin
            errors++;
            $error("FAIL accept_timeout in_ready %b want 1", in_ready);
        end
        if (in_ready) q.push_back({r, f});
        @(posedge clock);
    endtask

    task automatic idle();
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clock);
        chk("drain_empty", 36'(q.size()), 36'd0);
    endtask

    task automatic latency(input string tag);
        @(negedge clock);
        chk({tag, "_c1"}, {35'd0, out_valid}, 36'd0);
        @(negedge clock);
        chk({tag, "_c2"}, {35'd0, out_valid}, 36'd0);
        @(negedge clock);
        chk({tag, "_c3"}, {35'd0, out_valid}, 36'd1);
    endtask

    always @(negedge clock) begin
        #2;
        if (reset) q.delete();
        else if (out_valid) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output got %h want none", result);
            end
            if (q.size() != 0) begin
                chk(out_ready ? "result" : "stall_hold", {4'h0, result}, {4'h0, q[0][35:4]});
`ifdef FP_MULT_FLAGS_EN
                chk(out_ready ? "flags" : "stall_flags", {32'h0, flags}, {32'h0, q[0][3:0]});
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
        chk("rst_result", {4'h0, result}, 36'd0);
`ifdef FP_MULT_FLAGS_EN
        chk("rst_flags", {32'h0, flags}, 36'd0);
`endif
        reset = 1'b0;
        chk("rst_in_ready", {35'd0, in_ready}, 36'd1);

        send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
        idle();
        latency("lat_basic");
        drain();

        send(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0);
        send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0);
        send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1);
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0);
        send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
        send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1);
        send(32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h8);
        send(32'h7FC01234, 32'h3F800000, 32'h7FC00000, 4'h8);
        send(32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0);
        send(32'h80000000, 32'h3F800000, 32'h80000000, 4'h0);
        send(32'h00000001, 32'h40000000, 32'h00000000, 4'h0);
        send(32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5);
        send(32'h00800000, 32'h3F000000, 32'h00000000, 4'h3);
        idle();
        drain();

        @(negedge clock);
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h40000000, 4'h0);
        send(32'h40000000, 32'h40000000, 32'h40800000, 4'h0);
        send(32'h40400000, 32'h40000000, 32'h40C00000, 4'h0);
        idle();
        @(negedge clock);
        chk("bp_out_valid", {35'd0, out_valid}, 36'd1);
        chk("bp_in_ready", {35'd0, in_ready}, 36'd0);
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready_hold", {35'd0, in_ready}, 36'd0);
        end
        fork
            begin
                repeat (2) @(negedge clock);
                out_ready = 1'b1;
            end
            send(32'h40800000, 32'h40000000, 32'h41000000, 4'h0);
        join
        send(32'h40A00000, 32'h40000000, 32'h41200000, 4'h0);
        idle();
        drain();

        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0);
        send(32'h40000000, 32'h40000000, 32'h40800000, 4'h0);
        send(32'h40400000, 32'h40400000, 32'h41100000, 4'h0);
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_out_valid", {35'd0, out_valid}, 36'd0);
        reset = 1'b0;
        chk("mid_rst_in_ready", {35'd0, in_ready}, 36'd1);
        send(32'h40400000, 32'h40400000, 32'h41100000, 4'h0);
        idle();
        latency("lat_post_rst");
        drain();
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
